// File: rtl/nhit_trigger_ctrl_pkg.sv
// nhit_trigger_ctrl_pkg: shared defaults, FSM state encoding and counter sizing helper
package nhit_trigger_ctrl_pkg;
  localparam int DEF_OUT_N    = 8;
  localparam int DEF_WINDOW   = 16;
  localparam int DEF_CLR_CYC  = 4;
  localparam int DEF_HOLD_MAX = 32;
  localparam int DEF_TS_W     = 32;
  localparam int DROP_W       = 16;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_WINDOW  = 3'd1;
  localparam state_t S_EVAL    = 3'd2;
  localparam state_t S_CLEAR   = 3'd3;
  localparam state_t S_HOLDOFF = 3'd4;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/nhit_trigger_ctrl_if.sv
// nhit_trigger_ctrl_if: trigger record valid/ready channel
interface nhit_trigger_ctrl_if #(
  parameter int OUT_N = 8,
  parameter int TS_W  = 32
);
  logic             valid;
  logic             ready;
  logic [OUT_N-1:0] nhit;
  logic [TS_W-1:0]  ts;
  modport master (output valid, nhit, ts, input ready);
  modport slave  (input valid, nhit, ts, output ready);
endinterface

// File: rtl/nhit_trigger_ctrl_sync.sv
// nhit_trigger_ctrl_sync: two-flop synchroniser that only updates its output when two samples agree
module nhit_trigger_ctrl_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q1, r_q2, r_q;
  // a multi-bit popcount may be caught mid-transition, so hold until it settles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q1 <= '0;
      r_q2 <= '0;
      r_q  <= '0;
    end else begin
      r_q1 <= i_d;
      r_q2 <= r_q1;
      if (r_q1 == r_q2) r_q <= r_q2;
    end
  end
  assign o_q = r_q;
endmodule

// File: rtl/nhit_trigger_ctrl.sv
// nhit_trigger_ctrl: coincidence window, peak tracking, trigger record output and latch clearing
module nhit_trigger_ctrl
  import nhit_trigger_ctrl_pkg::*;
#(
  parameter int OUT_N    = DEF_OUT_N,
  parameter int WINDOW   = DEF_WINDOW,
  parameter int CLR_CYC  = DEF_CLR_CYC,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int TS_W     = DEF_TS_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OUT_N-1:0]    i_nhit,
  input  logic [OUT_N-1:0]    i_threshold,
  input  logic                i_enable,
  output logic                o_interrupt,
  nhit_trigger_ctrl_if.master trig,
  output logic [DROP_W-1:0]   o_drop_cnt,
  output logic                o_stuck
);
  localparam int CNT_W = $clog2(max3(WINDOW, CLR_CYC, HOLD_MAX) + 1);
  logic [OUT_N-1:0]  w_nhit_s, r_peak, r_tnhit;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TS_W-1:0]   r_ts, r_open_ts, r_tts;
  logic [DROP_W-1:0] r_drop;
  state_t            r_state, w_next;
  logic              w_active, w_fire, w_load, r_valid, r_int, r_stuck;
  nhit_trigger_ctrl_sync #(.W(OUT_N)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (i_nhit),
    .o_q   (w_nhit_s)
  );
  // next state, shared phase counter and record-emit decision
  always_comb begin
    w_active  = w_nhit_s != '0;
    w_next    = (r_state == S_IDLE)    ? (w_active ? S_WINDOW : S_IDLE) :
                (r_state == S_WINDOW)  ? ((r_cnt == CNT_W'(WINDOW - 1)) ? S_EVAL : S_WINDOW) :
                (r_state == S_EVAL)    ? S_CLEAR :
                (r_state == S_CLEAR)   ? ((r_cnt == CNT_W'(CLR_CYC - 1)) ? S_HOLDOFF : S_CLEAR) :
                (r_state == S_HOLDOFF) ? (!w_active ? S_IDLE :
                                          (r_cnt == CNT_W'(HOLD_MAX - 1)) ? S_CLEAR : S_HOLDOFF) :
                S_CLEAR;
    w_cnt_nxt = (w_next != r_state || r_state == S_IDLE) ? '0 : r_cnt + 1'b1;
    w_fire    = r_state == S_EVAL && i_enable && r_peak >= i_threshold;
    w_load    = w_fire && (!r_valid || trig.ready);
  end
  // FSM, timestamp, window capture; interrupt is decoded from the next state so it leaves a flop clean
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_cnt     <= '0;
      r_int     <= 1'b1;
      r_ts      <= '0;
      r_open_ts <= '0;
      r_peak    <= '0;
      r_stuck   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      r_int   <= w_next == S_CLEAR;
      r_ts    <= r_ts + 1'b1;
      if (r_state == S_IDLE && w_active) begin
        r_open_ts <= r_ts;
        r_peak    <= w_nhit_s;
      end else if (r_state == S_WINDOW && w_nhit_s > r_peak) r_peak <= w_nhit_s;
      if (r_state == S_HOLDOFF && w_next == S_CLEAR) r_stuck <= 1'b1;
    end
  end
  // output record register; a pending record is never overwritten, overflow only counts drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tnhit <= '0;
      r_tts   <= '0;
      r_drop  <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_tnhit <= r_peak;
        r_tts   <= r_open_ts;
      end else if (trig.ready) r_valid <= 1'b0;
      if (w_fire && !w_load && r_drop != '1) r_drop <= r_drop + 1'b1;
    end
  end
  assign o_interrupt = r_int;
  assign o_stuck     = r_stuck;
  assign o_drop_cnt  = r_drop;
  assign trig.valid  = r_valid;
  assign trig.nhit   = r_tnhit;
  assign trig.ts     = r_tts;
endmodule
